// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port arbiter: pipeline writeback over queued mul/div results.
// Optional macro WB_ARB_BYPASS_EN loads a mul/div result straight into the output register.
module reg_writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          WB_ENABLE,
  input  logic [ADDR_WIDTH-1:0]         WB_ADDRESS,
  input  logic [DATA_WIDTH-1:0]         WB_DATA,
  input  logic                          MD_VALID,
  input  logic [ADDR_WIDTH-1:0]         MD_ADDRESS,
  input  logic [DATA_WIDTH-1:0]         MD_DATA,
  output logic                          MD_READY,
  input  logic [ADDR_WIDTH-1:0]         RS1_ADDRESS,
  input  logic [ADDR_WIDTH-1:0]         RS2_ADDRESS,
  output logic                          HAZARD,
  output logic                          WRITE_ENABLE,
  output logic [ADDR_WIDTH-1:0]         WRITE_ADDRESS,
  output logic [DATA_WIDTH-1:0]         WRITE_DATA,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fa_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fd_q [FIFO_DEPTH];

  logic [PW-1:0]         rd_q, rd_d;
  logic [PW-1:0]         wr_q, wr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;

  logic wb_fire;
  logic md_hs;
  logic md_push;
  logic empty;
  logic byp;
  logic push;
  logic pop;
  logic hz;

  assign wb_fire = WB_ENABLE && (WB_ADDRESS != '0);
  assign empty   = (cnt_q == '0);
  assign MD_READY = RESET && (cnt_q < CW'(FIFO_DEPTH));
  assign md_hs   = MD_VALID && MD_READY;
  assign md_push = md_hs && (MD_ADDRESS != '0);

`ifdef WB_ARB_BYPASS_EN
  assign byp = md_push && empty && !wb_fire;
`else
  assign byp = 1'b0;
`endif

  assign push = md_push && !byp;
  assign pop  = !wb_fire && !empty;

  // Pick this cycle's write source and advance the queue pointers.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    we_d  = 1'b0;
    wa_d  = wa_q;
    wd_d  = wd_q;
    unique case (1'b1)
      wb_fire: begin
        we_d = 1'b1;
        wa_d = WB_ADDRESS;
        wd_d = WB_DATA;
      end
      pop: begin
        we_d = 1'b1;
        wa_d = fa_q[rd_q];
        wd_d = fd_q[rd_q];
        rd_d = rd_q + 1'b1;
      end
      byp: begin
        we_d = 1'b1;
        wa_d = MD_ADDRESS;
        wd_d = MD_DATA;
      end
      default: ;
    endcase
    if (push) wr_d = wr_q + 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Control state and output register; reset empties the queue at once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      we_q  <= we_d;
      wa_q  <= wa_d;
      wd_q  <= wd_d;
    end
  end

  // Queue storage; validity comes from the pointers, so no reset needed.
  always_ff @(posedge CLK) begin
    if (push) begin
      fa_q[wr_q] <= MD_ADDRESS;
      fd_q[wr_q] <= MD_DATA;
    end
  end

  function automatic logic src_hit(input logic [ADDR_WIDTH-1:0] a);
    return ((RS1_ADDRESS != '0) && (RS1_ADDRESS == a)) ||
           ((RS2_ADDRESS != '0) && (RS2_ADDRESS == a));
  endfunction

  // Flag a source register that still has a queued or registered write.
  always_comb begin
    hz = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((CW'(PW'(PW'(i) - rd_q)) < cnt_q) && src_hit(fa_q[i]))
        hz = 1'b1;
    end
    if (we_q && src_hit(wa_q))
      hz = 1'b1;
  end

  assign HAZARD        = RESET && hz;
  assign WRITE_ENABLE  = we_q;
  assign WRITE_ADDRESS = wa_q;
  assign WRITE_DATA    = wd_q;
  assign FIFO_COUNT    = cnt_q;

endmodule
